// File: rtl/ram_rd_streamer.sv
// Streams len words from a fixed-latency RAM starting at base_addr; out_valid trails start by 2+RD_LAT cycles.
// Reads are gated by buffer credit, so a stalled consumer throttles ram_re instead of dropping returned data.
module ram_rd_streamer #(
   parameter int WORDSZ    = 32,
   parameter int ADDRSZ    = 10,
   parameter int NWORDS    = 1024,
   parameter int LENSZ     = 11,
   parameter int RD_LAT    = 1,
   parameter int BUF_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDRSZ-1:0] base_addr,
   input  logic [LENSZ-1:0]  len,
   output logic              busy,
   output logic              done,
   output logic              ram_re,
   output logic [ADDRSZ-1:0] ram_raddr,
   input  logic [WORDSZ-1:0] ram_rdata,
   output logic              out_valid,
   output logic [WORDSZ-1:0] out_data,
   output logic              out_last,
   input  logic              out_ready
);

   localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
   localparam int CW = $clog2(BUF_DEPTH + 1);
   localparam int FW = $clog2(BUF_DEPTH + RD_LAT + 2) + 1;
   localparam logic [ADDRSZ-1:0] ADDR_LAST = ADDRSZ'(NWORDS - 1);
   localparam logic [PW-1:0]     PTR_LAST  = PW'(BUF_DEPTH - 1);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
   state_t state, state_nx;

   logic [ADDRSZ-1:0] next_addr;
   logic [LENSZ-1:0]  remaining;
   logic              rd_last;
   logic [RD_LAT-1:0] tag_vld;
   logic [RD_LAT-1:0] tag_last;
   logic [WORDSZ:0]   buf_mem [BUF_DEPTH];
   logic [PW-1:0]     wr_ptr, rd_ptr;
   logic [CW-1:0]     occ;
   logic [FW-1:0]     committed;
   logic              push, pop, head_last;
   logic              issue, issue_last, job_go, job_end, zero_job;

   function automatic logic [ADDRSZ-1:0] addr_inc(input logic [ADDRSZ-1:0] a);
      return (a == ADDR_LAST) ? '0 : a + ADDRSZ'(1);
   endfunction

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PTR_LAST) ? '0 : p + PW'(1);
   endfunction

   assign push      = tag_vld[RD_LAT-1];
   assign out_valid = (occ != '0);
   assign pop       = out_valid & out_ready;
   assign head_last = buf_mem[rd_ptr][WORDSZ];
   assign out_last  = out_valid & head_last;
   assign out_data  = out_valid ? buf_mem[rd_ptr][WORDSZ-1:0] : '0;
   assign busy      = (state != IDLE);
   assign zero_job  = (state == IDLE) && start && (len == '0);

   // Slots already spoken for: reads in flight plus buffered words, less the one leaving this cycle.
   always_comb begin
      committed = FW'(occ) + FW'(ram_re);
      for (int i = 0; i < RD_LAT; i++) begin
         committed = committed + FW'(tag_vld[i]);
      end
      committed = committed - FW'(pop);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx   = state;
      issue      = 1'b0;
      issue_last = 1'b0;
      job_go     = 1'b0;
      job_end    = 1'b0;
      case (state)
         IDLE: begin
            if (start && len != '0) begin
               job_go     = 1'b1;
               issue      = 1'b1;
               issue_last = (len == LENSZ'(1));
               state_nx   = ISSUE;
            end
         end
         ISSUE: begin
            if (remaining != '0 && committed < FW'(BUF_DEPTH)) begin
               issue      = 1'b1;
               issue_last = (remaining == LENSZ'(1));
            end
            if (remaining == '0 || issue_last) state_nx = DRAIN;
         end
         DRAIN: begin
            if (pop && head_last) begin
               job_end  = 1'b1;
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ram_re    <= 1'b0;
         rd_last   <= 1'b0;
         ram_raddr <= '0;
         next_addr <= '0;
         remaining <= '0;
         done      <= 1'b0;
         tag_vld   <= '0;
         tag_last  <= '0;
      end else begin
         ram_re  <= issue;
         rd_last <= issue_last;
         done    <= job_end | zero_job;
         if (job_go) begin
            ram_raddr <= base_addr;
            next_addr <= addr_inc(base_addr);
            remaining <= len - LENSZ'(1);
         end else if (issue) begin
            ram_raddr <= next_addr;
            next_addr <= addr_inc(next_addr);
            remaining <= remaining - LENSZ'(1);
         end
         // Tag pipeline mirrors the RAM latency so the write lands when ram_rdata is valid.
         tag_vld[0]  <= ram_re;
         tag_last[0] <= rd_last;
         for (int i = 1; i < RD_LAT; i++) begin
            tag_vld[i]  <= tag_vld[i-1];
            tag_last[i] <= tag_last[i-1];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         occ    <= '0;
      end else begin
         if (push) wr_ptr <= ptr_inc(wr_ptr);
         if (pop)  rd_ptr <= ptr_inc(rd_ptr);
         case ({push, pop})
            2'b10:   occ <= occ + CW'(1);
            2'b01:   occ <= occ - CW'(1);
            default: occ <= occ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) buf_mem[wr_ptr] <= {tag_last[RD_LAT-1], ram_rdata};
   end

endmodule

// File: tb/tb_ram_rd_streamer.sv
// Two streamers (RD_LAT 1 and 2) share stimulus; each is checked against a job-level model of address/data order.
module tb_ram_rd_streamer;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [9:0]  base_addr = '0;
   logic [10:0] len = '0;
   logic        out_ready = 1'b0;

   logic        re   [2];
   logic [9:0]  raddr[2];
   logic [31:0] rdata[2];
   logic        busy [2];
   logic        done [2];
   logic        ov   [2];
   logic        ol   [2];
   logic [31:0] od   [2];
   logic [31:0] rd2_a;
   logic [31:0] mem [1024];

   always #5 clk = ~clk;

   ram_rd_streamer #(.RD_LAT(1), .BUF_DEPTH(DEPTH)) u_lat1 (
      .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .len(len),
      .busy(busy[0]), .done(done[0]), .ram_re(re[0]), .ram_raddr(raddr[0]),
      .ram_rdata(rdata[0]), .out_valid(ov[0]), .out_data(od[0]), .out_last(ol[0]),
      .out_ready(out_ready));

   ram_rd_streamer #(.RD_LAT(2), .BUF_DEPTH(DEPTH)) u_lat2 (
      .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .len(len),
      .busy(busy[1]), .done(done[1]), .ram_re(re[1]), .ram_raddr(raddr[1]),
      .ram_rdata(rdata[1]), .out_valid(ov[1]), .out_data(od[1]), .out_last(ol[1]),
      .out_ready(out_ready));

   always @(posedge clk) begin
      if (re[0]) rdata[0] <= mem[raddr[0]];
      if (re[1]) rd2_a <= mem[raddr[1]];
      rdata[1] <= rd2_a;
   end

   int n_cmp = 0, n_err = 0, cyc = 0, rmode = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic        busy_m[2] = '{0, 0};
   logic        exp_done[2] = '{0, 0};
   logic        seen_first[2] = '{0, 0};
   int          jb[2] = '{0, 0}, jl[2] = '{0, 0}, nrd[2] = '{0, 0}, nwd[2] = '{0, 0};
   int          start_cyc[2] = '{0, 0}, ndone[2] = '{0, 0};
   logic [31:0] first_d[2], last_d[2];

   task automatic chk(input string nm, input int i, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s inst=%0d cyc=%0d: got %0h, expected %0h", nm, i, cyc, act, exp);
      end
   endtask

   task automatic fail(input string nm, input int i, input string act, input string exp);
      n_cmp++;
      n_err++;
      $display("FAIL %s inst=%0d cyc=%0d: got %s, expected %s", nm, i, cyc, act, exp);
   endtask

   // Job-level reference: one job per instance, word k comes from address (base+k) mod 1024.
   always @(negedge clk) begin
      logic bn, dn;
      int   a;
      for (int i = 0; i < 2; i++) begin
         if (rst) begin
            chk("rst_outs", i, {busy[i], done[i], re[i], ov[i], ol[i], raddr[i], od[i]}, '0);
            busy_m[i] = 0; exp_done[i] = 0; seen_first[i] = 0;
            jl[i] = 0; nrd[i] = 0; nwd[i] = 0;
         end else begin
            bn = busy_m[i];
            dn = 1'b0;
            if (done[i]) ndone[i]++;
            chk("done", i, done[i], exp_done[i]);
            chk("busy", i, busy[i], busy_m[i]);
            if (re[i]) begin
               if (!busy_m[i] || nrd[i] >= jl[i]) fail("extra_read", i, "ram_re=1", "no read");
               else begin
                  chk("raddr", i, raddr[i], (jb[i] + nrd[i]) % 1024);
                  chk("credit", i, (nrd[i] + 1 - nwd[i]) <= DEPTH, 1'b1);
                  nrd[i]++;
               end
            end
            if (ov[i]) begin
               if (!busy_m[i] || nwd[i] >= jl[i]) fail("extra_word", i, "out_valid=1", "no word");
               else begin
                  a = (jb[i] + nwd[i]) % 1024;
                  chk("data", i, od[i], mem[a]);
                  chk("last", i, ol[i], nwd[i] == jl[i] - 1);
                  if (!seen_first[i]) begin
                     chk("first_lat", i, cyc - start_cyc[i], 3 + i);
                     seen_first[i] = 1;
                  end
                  if (out_ready) begin
                     if (nwd[i] == 0) first_d[i] = od[i];
                     last_d[i] = od[i];
                     nwd[i]++;
                     if (nwd[i] == jl[i]) begin
                        dn = 1'b1;
                        bn = 1'b0;
                     end
                  end
               end
            end else if (rmode == 0 && busy_m[i] && seen_first[i]) begin
               fail("gap", i, "out_valid=0", "out_valid=1");
            end
            if (start && !busy_m[i]) begin
               if (len == '0) dn = 1'b1;
               else begin
                  bn = 1'b1; jb[i] = int'(base_addr); jl[i] = int'(len);
                  nrd[i] = 0; nwd[i] = 0; start_cyc[i] = cyc; seen_first[i] = 0;
               end
            end
            busy_m[i]   = bn;
            exp_done[i] = dn;
         end
      end
   end

   initial begin
      int tcnt = 0;
      forever begin
         @(posedge clk);
         #1;
         tcnt++;
         case (rmode)
            0:       out_ready = 1'b1;
            1:       out_ready = (tcnt % 4 == 0) || (tcnt % 4 == 3);
            default: out_ready = 1'($urandom % 2);
         endcase
      end
   end

   task automatic wait_idle(input int budget);
      int t = 0;
      repeat (2) @(posedge clk);
      while ((busy_m[0] || busy_m[1]) && t < budget) begin
         @(posedge clk);
         t++;
      end
      if (t >= budget) fail("timeout", 0, "still busy", "idle");
      repeat (3) @(posedge clk);
   endtask

   task automatic pulse_start(input int b, input int l);
      @(posedge clk); #1;
      start = 1'b1; base_addr = 10'(b); len = 11'(l);
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   typedef struct {
      int          base;
      int          len;
      int          mode;
      logic [31:0] first;
      logic [31:0] last;
   } vec_t;
   vec_t tbl[6];

   initial begin
      int d0[2];
      int t;
      for (int a = 0; a < 1024; a++) mem[a] = 32'h100 + a;
      tbl[0] = '{5,    8,  0, 32'h105, 32'h10C};
      tbl[1] = '{0,    16, 1, 32'h100, 32'h10F};
      tbl[2] = '{1020, 8,  0, 32'h4FC, 32'h103};
      tbl[3] = '{100,  32, 0, 32'h164, 32'h183};
      tbl[4] = '{7,    0,  0, 32'h0,   32'h0};
      tbl[5] = '{1023, 1,  0, 32'h4FF, 32'h4FF};

      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) chk("reset_state", i, {busy[i], done[i], re[i], ov[i], raddr[i]}, '0);
      rst = 1'b0;

      for (int k = 0; k < 6; k++) begin
         d0 = ndone;
         rmode = tbl[k].mode;
         pulse_start(tbl[k].base, tbl[k].len);
         wait_idle(4000);
         for (int i = 0; i < 2; i++) begin
            chk("job_done_cnt", i, ndone[i] - d0[i], 1);
            if (tbl[k].len > 0) begin
               chk("job_words", i, nwd[i], tbl[k].len);
               chk("job_first", i, first_d[i], tbl[k].first);
               chk("job_last", i, last_d[i], tbl[k].last);
            end
         end
      end

      // A start while busy must leave the running job untouched.
      d0 = ndone;
      rmode = 1;
      pulse_start(200, 10);
      repeat (4) @(posedge clk);
      pulse_start(0, 3);
      wait_idle(4000);
      for (int i = 0; i < 2; i++) begin
         chk("ign_done_cnt", i, ndone[i] - d0[i], 1);
         chk("ign_words", i, nwd[i], 10);
         chk("ign_first", i, first_d[i], 32'h1C8);
         chk("ign_last", i, last_d[i], 32'h1D1);
      end

      // Reset part-way through a job, then a fresh job.
      pulse_start(300, 10);
      t = 0;
      while (nwd[0] < 3 && t < 200) begin
         @(posedge clk);
         t++;
      end
      if (t >= 200) fail("rst_wait", 0, "fewer than 3 words", "3 words");
      #1 rst = 1'b1;
      #1;
      for (int i = 0; i < 2; i++) chk("rst_async", i, {busy[i], done[i], re[i], ov[i], ol[i], od[i]}, '0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      d0 = ndone;
      repeat (6) @(posedge clk);
      for (int i = 0; i < 2; i++) chk("rst_no_done", i, ndone[i] - d0[i], 0);
      rmode = 0;
      pulse_start(50, 6);
      wait_idle(4000);
      for (int i = 0; i < 2; i++) begin
         chk("post_rst_words", i, nwd[i], 6);
         chk("post_rst_first", i, first_d[i], 32'h132);
         chk("post_rst_last", i, last_d[i], 32'h137);
      end

      // Random contents, random starts (including during busy and on done), random backpressure.
      for (int a = 0; a < 1024; a++) mem[a] = $urandom;
      rmode = 2;
      repeat (3000) begin
         @(posedge clk); #1;
         start     = ($urandom % 6) == 0;
         base_addr = 10'($urandom);
         len       = 11'($urandom % 41);
      end
      @(posedge clk); #1;
      start = 1'b0;
      wait_idle(4000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/ram_rd_streamer.md
Name: ram_rd_streamer

Overview:
- Read-side controller for a 1-read/1-write RAM wrapper.
- Accepts a (base address, length) job and issues `ram_re`/`ram_raddr` to the RAM.
- Absorbs the RAM's fixed read latency into a small credit-managed buffer and presents the words as a valid/ready stream with a last flag.
- Sits between MSM bucket/point RAMs and downstream pipeline consumers that may stall.

Parameters:
- WORDSZ, 32, RAM data width and out_data width
- ADDRSZ, 10, RAM address width
- NWORDS, 1024, RAM depth; address wraps from NWORDS-1 to 0
- LENSZ, 11, job length width (max len = 2^LENSZ-1)
- RD_LAT, 1, cycles from ram_re to valid ram_rdata (1 = FLOPOUT 0, 2 = FLOPOUT 1)
- BUF_DEPTH, 4, output buffer entries; must be >= RD_LAT+2 for 1 word/cycle throughput

Ports:
- clk  in  1  single clock
- rst  in  1  asynchronous reset, active-high
- start  in  1  job request pulse, accepted only in IDLE
- base_addr  in  ADDRSZ  first RAM address of job
- len  in  LENSZ  number of words to read
- busy  out  1  job in progress
- done  out  1  one-cycle pulse at job completion
- ram_re  out  1  RAM read enable
- ram_raddr  out  ADDRSZ  RAM read address
- ram_rdata  in  WORDSZ  RAM read data, valid RD_LAT cycles after ram_re
- out_valid  out  1  out_data valid
- out_data  out  WORDSZ  streamed word
- out_last  out  1  final word of job, qualified by out_valid
- out_ready  in  1  downstream accepts word

Behaviour:
- Reset values: all outputs 0; state IDLE; buffer empty; in-flight read pipeline cleared. Reset mid-job discards all pending reads and buffered words, and no done pulse is produced.
- States: IDLE, ISSUE, DRAIN.
- IDLE:
  - start=1 and len>0: latch base_addr/len, go to ISSUE, busy=1 next cycle.
  - start=1 and len=0: stay in IDLE, done=1 next cycle, busy stays 0, no reads issued.
  - start outside IDLE is ignored.
- ISSUE:
  - Each cycle, ram_re=1 if remaining>0 and credit>0, where credit = BUF_DEPTH - (reads in flight + buffer occupancy).
  - ram_re and ram_raddr are registered outputs. First ram_re occurs the cycle after start.
  - Address increments per issued read and wraps NWORDS-1 -> 0 (not 2^ADDRSZ).
  - When the last read is issued, go to DRAIN.
- DRAIN: no reads. When the handshake on the word with out_last completes, go to IDLE; done=1 and busy=0 on the following cycle.
- Read return:
  - A shift register of depth RD_LAT tracks issued reads, tagged with a last bit.
  - ram_rdata is written into the buffer in the cycle the tag emerges.
  - Buffer writes never overflow, by construction of the credit.
- Output:
  - out_valid = buffer non-empty; out_data/out_last come from the head entry.
  - Handshake is out_valid & out_ready.
  - out_data/out_last are held stable while out_valid=1 and out_ready=0.
  - The buffer supports write and read in the same cycle, including when full.
- Latency: start at cycle 0 -> ram_re cycle 1 -> data buffered at end of cycle 1+RD_LAT -> out_valid at cycle 2+RD_LAT.
- Throughput: 1 word/cycle when out_ready=1 and BUF_DEPTH >= RD_LAT+2.
- out_last is set only on the word from read number len (1-based).
- start in the same cycle as done: accepted, since state is already IDLE.
- Counters: remaining is LENSZ bits and never underflows. Occupancy counter width is clog2(BUF_DEPTH+1).

Test Plan:
- Basic stream: RD_LAT=1, RAM[i]=i+0x100, start base=5 len=8, out_ready=1 -> out_valid first at cycle 3; data 0x105..0x10C one per cycle; out_last with 0x10C only; done one cycle after last handshake.
- Backpressure: len=16, out_ready toggles 1,0,0,1 repeating -> no word lost or duplicated; ram_re never issued when credit=0; out_data stable during stall cycles.
- Wrap-around: NWORDS=1024, base=1020, len=8 -> ram_raddr sequence 1020,1021,1022,1023,0,1,2,3; data in matching order.
- Zero length and ignored start: start len=0 -> done pulse next cycle, busy=0, ram_re never asserted; start pulsed mid-job -> ignored, job unaffected.
- RD_LAT=2, BUF_DEPTH=4, len=32, out_ready=1 -> sustained 1 word/cycle after fill; 32 words in order; out_valid first at cycle 4.
- Reset mid-job: assert rst after 3 of 10 words accepted -> all outputs 0 immediately; no done; a new start afterwards streams the full new job correctly.
